// File: rtl/mux_n_pipe.sv
// N-way operand select stage: registers in_data[sel] into a 2-entry head/skid FIFO
// behind valid/ready; illegal sel replays the last legal value. Optional MUX_N_PIPE_PARITY_EN adds out_par.
module mux_n_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    sel_err
`ifdef MUX_N_PIPE_PARITY_EN
  ,
  output logic                    out_par
`endif
);

  // Handshake: a beat moves on a posedge when valid & ready are both high.
  // in_ready depends only on registered count, never on out_ready.
  logic [1:0]       count;
  logic [WIDTH-1:0] data0, data1, last_good;
  logic             err0, err1;
  logic [WIDTH-1:0] sel_data, new_data;
  logic             legal, new_err;
  logic             accept, deliver;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid & in_ready & ~flush;
  assign deliver   = out_valid & out_ready;

  always_comb begin
    sel_data = '0;
    legal    = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
        legal    = 1'b1;
      end
    end
    new_data = legal ? sel_data : last_good;
    new_err  = ~legal;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= 2'd0;
      data0     <= '0;
      data1     <= '0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      last_good <= '0;
    end else begin
      if (accept && legal) last_good <= sel_data;
      if (flush) begin
        count <= 2'd0;
      end else if (accept && deliver) begin
        // Only reachable at count 1: the new beat replaces the departing head.
        data0 <= new_data;
        err0  <= new_err;
      end else if (accept) begin
        if (count == 2'd0) begin
          data0 <= new_data;
          err0  <= new_err;
        end else begin
          data1 <= new_data;
          err1  <= new_err;
        end
        count <= count + 2'd1;
      end else if (deliver) begin
        data0 <= data1;
        err0  <= err1;
        count <= count - 2'd1;
      end
    end
  end

  assign out_data = out_valid ? data0 : '0;
  assign sel_err  = out_valid & err0;

`ifdef MUX_N_PIPE_PARITY_EN
  logic par0, par1;

  always_ff @(posedge clk) begin
    if (reset) begin
      par0 <= 1'b0;
      par1 <= 1'b0;
    end else if (!flush) begin
      if (accept && (deliver || count == 2'd0)) par0 <= ^new_data;
      else if (accept)                          par1 <= ^new_data;
      else if (deliver)                         par0 <= par1;
    end
  end

  assign out_par = out_valid & ~reset & par0;
`endif

endmodule
